regfile_param: RTL

Parametrised general-purpose register file: the next generation of the core's integer register bank. It provides configurable width, depth and read-port count, and an optional hard-wired zero register. A handshaked register-dump engine streams every register out one per cycle, for the VGA debug overlay and for trace capture. It sits in the decode stage of the RV32 datapath; the dump port feeds the display/trace subsystem.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_dump_fsm.sv | 75 +++++++
 rtl/regfile_param.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its dump engine.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Register-dump sequencer: one beat per cycle after dump_start, first beat the cycle after start.
// Index and load enable freeze while dump_valid && !dump_ready; done pulses one cycle after the last accept.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_busy,
    output logic          dump_valid,
    output logic          dump_done,
    output logic [AW-1:0] dump_idx,
    output logic [AW-1:0] dump_rd_addr,
    output logic          dump_load
);

    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          w_last;

    assign w_last = (r_idx == AW'(NREGS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        dump_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (dump_start) begin
                    w_state_nxt = SEND;
                    w_idx_nxt   = '0;
                    dump_load   = 1'b1;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        dump_load = 1'b1;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The holding register is loaded from the index the FSM is about to present.
    assign dump_rd_addr = w_idx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Outputs are forced low while reset is held, even before the first reset edge.
    assign dump_valid = !reset && (r_state == SEND);
    assign dump_done  = !reset && (r_state == DONE);
    assign dump_busy  = !reset && (r_state != IDLE);
    assign dump_idx   = reset ? '0 : r_idx;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file, combinational reads, handshaked dump stream (dump_ready backpressure holds the beat).
// Define REGFILE_BYPASS_EN for write-first read bypass; default is read-before-write.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rs_addr,
    output logic [NUM_RD*XLEN-1:0] rs_data,
    input  logic                   we,
    input  logic [AW-1:0]          rd,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   dump_start,
    output logic                   dump_busy,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [AW-1:0]          dump_idx,
    output logic [XLEN-1:0]        dump_data,
    output logic                   dump_done
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] r_dump_data;
    logic [AW-1:0]   w_dump_addr;
    logic            w_dump_load;
    logic            w_wr_en;

    assign w_wr_en = we && !((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= wdata;
        end
    end

    // Loaded from the pre-edge array contents, so a same-edge write is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dump_data <= '0;
        end else if (w_dump_load) begin
            r_dump_data <= r_regs[w_dump_addr];
        end
    end

    assign dump_data = reset ? '0 : r_dump_data;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_stored;
        logic [XLEN-1:0] w_data;

        assign w_addr   = rs_addr[k*AW +: AW];
        assign w_stored = ((ZERO_REG != 0) && (w_addr == '0)) ? '0 : r_regs[w_addr];
`ifdef REGFILE_BYPASS_EN
        assign w_data   = (w_wr_en && (w_addr == rd)) ? wdata : w_stored;
`else
        assign w_data   = w_stored;
`endif
        assign rs_data[k*XLEN +: XLEN] = reset ? '0 : w_data;
    end

    regfile_dump_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_fsm (
        .clk          (clk),
        .reset        (reset),
        .dump_start   (dump_start),
        .dump_ready   (dump_ready),
        .dump_busy    (dump_busy),
        .dump_valid   (dump_valid),
        .dump_done    (dump_done),
        .dump_idx     (dump_idx),
        .dump_rd_addr (w_dump_addr),
        .dump_load    (w_dump_load)
    );

endmodule
